// File: rtl/io_handshake_unit_if.sv
// Handshake bundle between the control unit / user I/O (master) and io_handshake_unit (slave).
interface io_handshake_unit_if #(
    parameter int DATA_W = 32,
    parameter int SW_W   = 16
);
    logic              In;
    logic              Out;
    logic              Halt;
    logic [DATA_W-1:0] out_data;
    logic [SW_W-1:0]   switches;
    logic              confirm_btn;
    logic              enable_clock;
    logic [DATA_W-1:0] in_data;
    logic              in_done;
    logic [DATA_W-1:0] display;
    logic              display_valid;
    logic              halted;

    modport master (
        output In, Out, Halt, out_data, switches, confirm_btn,
        input  enable_clock, in_data, in_done, display, display_valid, halted
    );

    modport slave (
        input  In, Out, Halt, out_data, switches, confirm_btn,
        output enable_clock, in_data, in_done, display, display_valid, halted
    );
endinterface

// File: rtl/io_handshake_unit.sv
// Responder for In/Out/Halt strobes: gates the processor clock during a debounced switch entry.
// Optional macro IO_SIGN_EXTEND_EN: sign-extend the captured switch value instead of zero-extending.
module io_handshake_unit #(
    parameter int DATA_W          = 32,
    parameter int SW_W            = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input logic               clock,
    input logic               reset,
    io_handshake_unit_if.slave io
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WAIT_PRESS   = 3'd1,
        ST_WAIT_RELEASE = 3'd2,
        ST_CAPTURE      = 3'd3,
        ST_HALTED       = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [SW_W-1:0]   in_reg_q, in_reg_d;
    logic [DATA_W-1:0] display_q, display_d;
    logic              display_valid_q, display_valid_d;
    logic              enable_clock_s;

    function automatic logic [DATA_W-1:0] extend(input logic [SW_W-1:0] v);
`ifdef IO_SIGN_EXTEND_EN
        extend = DATA_W'($signed(v));
`else
        extend = DATA_W'(v);
`endif
    endfunction

    assign enable_clock_s = (state_q == ST_CAPTURE) ||
                            ((state_q == ST_IDLE) && !io.In && !io.Halt);

    // Next-state, debounce counting and display update
    always_comb begin
        state_d         = state_q;
        deb_cnt_d       = deb_cnt_q;
        in_reg_d        = in_reg_q;
        display_d       = display_q;
        display_valid_d = display_valid_q;

        if (io.Out && enable_clock_s) begin
            display_d       = io.out_data;
            display_valid_d = 1'b1;
        end else begin
            display_d       = display_q;
            display_valid_d = display_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (io.Halt) begin
                    state_d = ST_HALTED;
                end else if (io.In) begin
                    state_d   = ST_WAIT_PRESS;
                    deb_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_PRESS: begin
                // The transition fires on the increment that would reach DEBOUNCE_CYCLES, so no wrap
                if (io.confirm_btn) begin
                    if (deb_cnt_q == CNT_LAST) begin
                        in_reg_d  = io.switches;
                        deb_cnt_d = '0;
                        state_d   = ST_WAIT_RELEASE;
                    end else begin
                        deb_cnt_d = deb_cnt_q + CNT_W'(1);
                    end
                end else begin
                    deb_cnt_d = '0;
                end
            end
            ST_WAIT_RELEASE: begin
                if (!io.confirm_btn) begin
                    if (deb_cnt_q == CNT_LAST) begin
                        deb_cnt_d = '0;
                        state_d   = ST_CAPTURE;
                    end else begin
                        deb_cnt_d = deb_cnt_q + CNT_W'(1);
                    end
                end else begin
                    deb_cnt_d = '0;
                end
            end
            ST_CAPTURE: begin
                state_d = ST_IDLE;
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d   = ST_IDLE;
                deb_cnt_d = '0;
            end
        endcase
    end

    // State and data registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            deb_cnt_q       <= '0;
            in_reg_q        <= '0;
            display_q       <= '0;
            display_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            deb_cnt_q       <= deb_cnt_d;
            in_reg_q        <= in_reg_d;
            display_q       <= display_d;
            display_valid_q <= display_valid_d;
        end
    end

    assign io.enable_clock  = enable_clock_s;
    assign io.in_done       = (state_q == ST_CAPTURE);
    assign io.in_data       = extend(in_reg_q);
    assign io.display       = display_q;
    assign io.display_valid = display_valid_q;
    assign io.halted        = (state_q == ST_HALTED);
endmodule
